// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU and DMA request ports, memory port and status.
// The slave modport is the arbiter's view; master is the environment's view
// (requesters plus the memory itself).
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
);
  // CPU (priority) requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // DMA / test-loader requester
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  // Single-port synchronous memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-2:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// Every access runs IDLE -> ACCESS -> RESP. The CPU has priority, but after
// MAX_CPU_BURST CPU grants with the DMA waiting, the DMA is forced through.
module dmem_arbiter #(
  parameter int unsigned ADDR_W        = 7,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned MAX_CPU_BURST = 4
) (
  input logic            clk,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned BurstW = $clog2(MAX_CPU_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_CPU_BURST);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic {OwnCpu, OwnDma} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic              grant_cpu, grant_dma;
  logic              in_access, in_resp;
  logic              resp_cpu, resp_dma;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  // Byte-address bit 0 selects nothing in a word-wide memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = bus.cpu_addr[0] ^ bus.dma_addr[0];

  // Arbitration, starvation counter and FSM next state.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    unique case (state_q)
      StIdle: begin
        // DMA wins if it is alone, or if the CPU has used up its burst allowance.
        grant_dma = bus.dma_req & (~bus.cpu_req | (burst_q == BurstMax));
        grant_cpu = bus.cpu_req & ~grant_dma;
        if (grant_cpu || grant_dma) begin
          state_d = StAccess;
          owner_d = grant_dma ? OwnDma : OwnCpu;
        end
        if (grant_dma || !bus.dma_req) begin
          burst_d = '0;
        end else if (grant_cpu && (burst_q != BurstMax)) begin
          burst_d = burst_q + BurstW'(1);
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Steer the owning requester onto the memory port; addresses are used live.
  always_comb begin
    own_we    = bus.cpu_we;
    own_addr  = bus.cpu_addr;
    own_wdata = bus.cpu_wdata;
    if (owner_q == OwnDma) begin
      own_we    = bus.dma_we;
      own_addr  = bus.dma_addr;
      own_wdata = bus.dma_wdata;
    end
  end

  // Memory strobes, acks and read-data capture; reset kills any in-flight beat.
  always_comb begin
    in_access   = (state_q == StAccess) & ~reset;
    in_resp     = (state_q == StResp) & ~reset;
    resp_cpu    = in_resp & (owner_q == OwnCpu);
    resp_dma    = in_resp & (owner_q == OwnDma);
    // Read data is bypassed in the ack cycle and then held by the register.
    cpu_rdata_d = resp_cpu ? bus.mem_rdata : cpu_rdata_q;
    dma_rdata_d = resp_dma ? bus.mem_rdata : dma_rdata_q;
  end

  assign bus.mem_en    = in_access;
  assign bus.mem_we    = in_access & own_we;
  assign bus.mem_addr  = own_addr[ADDR_W-1:1];
  assign bus.mem_wdata = own_wdata;

  assign bus.cpu_ack   = resp_cpu;
  assign bus.cpu_rdata = cpu_rdata_d;
  assign bus.cpu_stall = bus.cpu_req & ~resp_cpu & ~reset;
  assign bus.dma_ack   = resp_dma;
  assign bus.dma_rdata = dma_rdata_d;
  assign bus.busy      = (state_q != StIdle);

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      burst_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule
